text_term_writer: RTL and testbench



---
 rtl/text_term_pkg.sv | 26 ++
 rtl/text_term_writer_if.sv | 20 ++
 rtl/text_cell_sweep.sv | 49 ++++
 rtl/text_term_writer.sv | 164 ++++++++++++++++
 tb/tb_text_term_writer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/text_term_pkg.sv
// Shared constants, state codes and address packing for the 30x17 text terminal writer.
package text_term_pkg;

  localparam int COLS = 30;
  localparam int ROWS = 17;
  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [4:0] COL_LAST = 5'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PUT     = 2'd1;
  localparam state_t ST_CLRLINE = 2'd2;
  localparam state_t ST_CLS     = 2'd3;

  function automatic logic [9:0] pack_addr(input logic [4:0] row, input logic [4:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_term_writer_if.sv
// Byte-stream input handshake and text RAM port A write bus of the terminal writer.
interface text_term_writer_if;
  logic [7:0]  chr_i;
  logic [7:0]  attr_i;
  logic        valid_i;
  logic        ready_o;
  logic        wr_en_o;
  logic [9:0]  wr_addr_o;
  logic [15:0] wr_data_o;

  modport slave (
    input  chr_i, attr_i, valid_i,
    output ready_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport master (
    output chr_i, attr_i, valid_i,
    input  ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/text_cell_sweep.sv
// Row-major cell sweep over rows row_lo..row_hi, cols 0..COLS-1; the first cell is
// presented combinationally in the start cycle so the caller can register it at once.
module text_cell_sweep
  import text_term_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [4:0] row_lo_i,
  input  logic [4:0] row_hi_i,
  output logic       emit_o,
  output logic [4:0] row_o,
  output logic [4:0] col_o,
  output logic       done_o
);

  logic       active_q, active_d;
  logic [4:0] row_q, row_d, col_q, col_d, hi_q, hi_d;
  logic       last;

  always_comb begin
    emit_o   = start_i | active_q;
    row_o    = start_i ? row_lo_i : row_q;
    col_o    = start_i ? 5'd0 : col_q;
    hi_d     = start_i ? row_hi_i : hi_q;
    last     = (col_o == COL_LAST) && (row_o == hi_d);
    done_o   = !emit_o;
    active_d = emit_o && !last;
    if (col_o == COL_LAST) begin
      col_d = 5'd0;
      row_d = row_o + 5'd1;
    end else begin
      col_d = col_o + 5'd1;
      row_d = row_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) active_q <= 1'b0;
    else       active_q <= active_d;
  end

  always_ff @(posedge clk_i) begin
    row_q <= row_d;
    col_q <= col_d;
    hi_q  <= hi_d;
  end

endmodule

// File: rtl/text_term_writer.sv
// Terminal front end: interprets a byte stream, tracks the cursor and writes text RAM cells.
// Define TEXT_TERM_CLS_EN to make 0x0C clear the whole screen.
module text_term_writer
  import text_term_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  text_term_writer_if.slave  bus,
  output logic [4:0]         cur_row_o,
  output logic [4:0]         cur_col_o
);

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d, col_q, col_d;
  logic [7:0]  attr_q, attr_d;
  logic        adv_q, adv_d;
  logic        ready_q, ready_d;
  logic        wr_en_q, wr_en_d;
  logic [9:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic        sw_start, sw_emit, sw_done;
  logic [4:0]  sw_lo, sw_hi, sw_row, sw_col;
  logic [4:0]  next_row;
  logic [7:0]  ch;
  logic        accept;

  text_cell_sweep u_sweep (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (sw_start),
    .row_lo_i (sw_lo),
    .row_hi_i (sw_hi),
    .emit_o   (sw_emit),
    .row_o    (sw_row),
    .col_o    (sw_col),
    .done_o   (sw_done)
  );

  always_comb begin
    ch       = bus.chr_i;
    accept   = bus.valid_i & ready_q;
    next_row = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    attr_d   = attr_q;
    adv_d    = adv_q;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    sw_start = 1'b0;
    sw_lo    = row_q;
    sw_hi    = row_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Every accepted byte leaves IDLE for at least one cycle.
          attr_d  = bus.attr_i;
          adv_d   = 1'b0;
          state_d = ST_PUT;
          if (ch >= 8'h20 && ch <= 8'h7E) begin
            wr_en_d = 1'b1;
            addr_d  = pack_addr(row_q, col_q);
            data_d  = {bus.attr_i, ch};
            if (col_q == COL_LAST) begin
              col_d = 5'd0;
              row_d = next_row;
              adv_d = 1'b1;
            end else begin
              col_d = col_q + 5'd1;
            end
          end else if (ch == CHR_CR) begin
            col_d = 5'd0;
          end else if (ch == CHR_LF) begin
            col_d    = 5'd0;
            row_d    = next_row;
            sw_start = 1'b1;
            sw_lo    = next_row;
            sw_hi    = next_row;
            state_d  = ST_CLRLINE;
          end else if (ch == CHR_BS) begin
            if (col_q != 5'd0) begin
              col_d   = col_q - 5'd1;
              wr_en_d = 1'b1;
              addr_d  = pack_addr(row_q, col_q - 5'd1);
              data_d  = {bus.attr_i, BLANK};
            end
`ifdef TEXT_TERM_CLS_EN
          end else if (ch == CHR_FF) begin
            row_d    = 5'd0;
            col_d    = 5'd0;
            sw_start = 1'b1;
            sw_lo    = 5'd0;
            sw_hi    = ROW_LAST;
            state_d  = ST_CLS;
`endif
          end
        end
      end
      ST_PUT: begin
        // Cursor already holds the new row when a wrap is pending.
        adv_d = 1'b0;
        if (adv_q) begin
          sw_start = 1'b1;
          state_d  = ST_CLRLINE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLRLINE: begin
        if (sw_done) state_d = ST_IDLE;
      end
`ifdef TEXT_TERM_CLS_EN
      ST_CLS: begin
        if (sw_done) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (sw_emit) begin
      wr_en_d = 1'b1;
      addr_d  = pack_addr(sw_row, sw_col);
      data_d  = {attr_d, BLANK};
    end
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      row_q   <= 5'd0;
      col_q   <= 5'd0;
      adv_q   <= 1'b0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= 10'd0;
      data_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      adv_q   <= adv_d;
      ready_q <= ready_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    attr_q <= attr_d;
  end

  assign bus.ready_o   = ready_q;
  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = addr_q;
  assign bus.wr_data_o = data_q;
  assign cur_row_o     = row_q;
  assign cur_col_o     = col_q;

endmodule

// File: tb/tb_text_term_writer.sv
// Bench for text_term_writer: directed and random byte streams against a cell-level screen model.
module tb_text_term_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] cur_row, cur_col;

  text_term_writer_if bus ();

  text_term_writer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .cur_row_o (cur_row),
    .cur_col_o (cur_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int off;
    int addr;
    int data;
  } wr_t;

  wr_t expq[$];
  int  m_row = 0;
  int  m_col = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_row(input int start_off, input logic [7:0] a);
    for (int cc = 0; cc < 30; cc++)
      expq.push_back('{start_off + cc, m_row * 32 + cc, int'({a, 8'h20})});
  endtask

  // lat: cycles from accept to ready; 0 means "no more than 2"
  task automatic model(input logic [7:0] ch, input logic [7:0] a, output int lat);
    lat = 0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      expq.push_back('{1, m_row * 32 + m_col, int'({a, ch})});
      m_col++;
      lat = 2;
      if (m_col == 30) begin
        m_col = 0;
        m_row = (m_row + 1) % 17;
        clear_row(2, a);
        lat = 32;
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % 17;
      clear_row(1, a);
      lat = 31;
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        expq.push_back('{1, m_row * 32 + m_col, int'({a, 8'h20})});
        lat = 2;
      end
`ifdef TEXT_TERM_CLS_EN
    end else if (ch == 8'h0C) begin
      for (int rr = 0; rr < 17; rr++)
        for (int cc = 0; cc < 30; cc++)
          expq.push_back('{1 + rr * 30 + cc, rr * 32 + cc, int'({a, 8'h20})});
      m_row = 0;
      m_col = 0;
      lat = 511;
`endif
    end
  endtask

  task automatic send(input logic [7:0] ch, input logic [7:0] a);
    int  lat, n, kr;
    wr_t e;
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", {31'd0, bus.ready_o}, 32'd1);
    model(ch, a, lat);
    bus.chr_i   = ch;
    bus.attr_i  = a;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.chr_i   = 8'($urandom);
    bus.attr_i  = 8'($urandom);
    kr = 0;
    for (int k = 1; k <= 600 && kr == 0; k++) begin
      @(negedge clk);
      if (bus.wr_en_o === 1'b1) begin
        if (expq.size() == 0) begin
          chk("extra_write_addr", {22'd0, bus.wr_addr_o}, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          chk("wr_cycle", k, e.off);
          chk("wr_addr", {22'd0, bus.wr_addr_o}, e.addr);
          chk("wr_data", {16'd0, bus.wr_data_o}, e.data);
        end
      end
      if (bus.ready_o === 1'b1) kr = k;
    end
    if (kr == 0) chk("ready_timeout", {31'd0, bus.ready_o}, 32'd1);
    else if (lat == 0) chk("ready_latency_le2", {31'd0, kr <= 2}, 32'd1);
    else chk("ready_latency", kr, lat);
    chk("missing_writes", expq.size(), 0);
    expq.delete();
    chk("cur_row", {27'd0, cur_row}, m_row);
    chk("cur_col", {27'd0, cur_col}, m_col);
  endtask

  function automatic logic [7:0] rand_byte();
    int sel;
    sel = $urandom_range(0, 11);
    if (sel <= 5) return 8'($urandom_range(32, 126));
    if (sel == 6) return 8'h0D;
    if (sel == 7) return 8'h0A;
    if (sel == 8) return 8'h08;
    if (sel == 9) return 8'h0C;
    if (sel == 10) return 8'($urandom_range(127, 255));
    return 8'($urandom_range(0, 31));
  endfunction

  initial begin
    bus.valid_i = 1'b0;
    bus.chr_i   = 8'h00;
    bus.attr_i  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready_o}, 32'd0);
    chk("rst_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
    chk("rst_wr_addr", {22'd0, bus.wr_addr_o}, 32'd0);
    chk("rst_wr_data", {16'd0, bus.wr_data_o}, 32'd0);
    chk("rst_cur_row", {27'd0, cur_row}, 32'd0);
    chk("rst_cur_col", {27'd0, cur_col}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, bus.ready_o}, 32'd1);

    send(8'h41, 8'h1F);
    send(8'h0D, 8'h00);
    for (int i = 0; i < 30; i++) send(8'($urandom_range(32, 126)), 8'($urandom));
    for (int i = 0; i < 15; i++) send(8'h0A, 8'($urandom));
    for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)), 8'($urandom));
    send(8'h0A, 8'h07);
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h07);
    send(8'h08, 8'h4E);
    for (int i = 0; i < 4; i++) send(8'($urandom_range(32, 126)), 8'h4E);
    send(8'h08, 8'h5A);

    // reset in the middle of a line clear
    bus.chr_i   = 8'h0A;
    bus.attr_i  = 8'h07;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_sweep_wr_en", {31'd0, bus.wr_en_o}, 32'd1);
    chk("mid_sweep_row", {27'd0, cur_row}, 32'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_wr_en", {31'd0, bus.wr_en_o}, 32'd0);
    chk("abort_cur_row", {27'd0, cur_row}, 32'd0);
    chk("abort_cur_col", {27'd0, cur_col}, 32'd0);
    chk("abort_ready", {31'd0, bus.ready_o}, 32'd0);
    @(negedge clk);
    chk("abort_wr_en_hold", {31'd0, bus.wr_en_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", {31'd0, bus.ready_o}, 32'd1);
    m_row = 0;
    m_col = 0;

    send(8'h5A, 8'h3C);
    for (int i = 0; i < 60; i++) send(rand_byte(), 8'($urandom));
    send(8'h0C, 8'h17);
    send(8'h71, 8'h21);
    send(8'hFF, 8'h21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
